// File: rtl/fp16_sqrt_pkg.sv
// Shared types and constants for the FP16 square-root unit.
package fp16_sqrt_pkg;

  localparam int FP16_BIAS = 15;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam int ROOT_W = 12;
  localparam int EXP_W = 7;

  typedef struct packed {
    logic [15:0] data;
    logic        inexact;
  } sqrt_res_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fp16_sqrt_result_stage_if.sv
// Result-stage bus: finished root fields in, packed FP16 word out, both valid/ready.
interface fp16_sqrt_result_stage_if;
  import fp16_sqrt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [ROOT_W-1:0] in_root;
  logic             in_rem_nz;
  logic             in_is_nan;
  logic             in_is_inf;
  logic             in_is_zero;
  logic [9:0]       in_nan_mant;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_root, in_rem_nz,
           in_is_nan, in_is_inf, in_is_zero, in_nan_mant, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_root, in_rem_nz,
           in_is_nan, in_is_inf, in_is_zero, in_nan_mant, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );

endinterface

// File: rtl/fp16_sqrt_round_pack.sv
// Round-to-nearest-even (or truncate) and FP16 packing of a finished root; zero latency.
module fp16_sqrt_round_pack
  import fp16_sqrt_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [ROOT_W-1:0]       in_root,
  input  logic                    in_rem_nz,
  input  logic                    in_is_nan,
  input  logic                    in_is_inf,
  input  logic                    in_is_zero,
  input  logic [9:0]              in_nan_mant,
  output sqrt_res_t               res
);

  logic                    guard_bit;
  logic                    round_up;
  logic [10:0]             low_sum;
  logic                    carry;
  logic [9:0]              frac;
  logic signed [EXP_W-1:0] eb;
  logic                    special;

  // The fraction add only carries out of the hidden bit when the whole
  // significand is all ones, which leaves frac at zero on its own.
  always_comb begin
    guard_bit = in_root[0];
    round_up  = ROUND_EN & guard_bit & (in_rem_nz | in_root[1]);
    low_sum   = {1'b0, in_root[10:1]} + {10'b0, round_up};
    frac      = low_sum[9:0];
    carry     = in_root[11] & low_sum[10];
    eb        = in_exp + $signed(7'(FP16_BIAS)) + $signed({6'b0, carry});
    special   = in_is_nan | in_is_inf | in_is_zero;
  end

  always_comb begin
    res.inexact = (guard_bit | in_rem_nz) & ~special;
    if (in_is_nan)         res.data = {in_sign, 5'b11111, in_nan_mant};
    else if (in_is_inf)    res.data = FP16_PINF;
    else if (in_is_zero)   res.data = {in_sign, 15'b0};
    else if (eb >= 7'sd31) res.data = FP16_PINF;
    else if (eb <= 7'sd0)  res.data = {in_sign, 15'b0};
    else                   res.data = {1'b0, eb[4:0], frac};
  end

endmodule

// File: rtl/mux2_n.sv
// N-bit two-way multiplexer; sel=1 picks b. Purely combinational.
module mux2_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/register_n.sv
// N-bit enabled register with asynchronous active-high reset to RST_VAL.
module register_n #(
  parameter int          N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fp16_sqrt_result_stage.sv
// FP16 sqrt output stage: round/pack then a 2-slot skid buffer; result valid one edge after accept.
// in_ready is registered and drops only once the skid slot fills under out_ready backpressure.
module fp16_sqrt_result_stage
  import fp16_sqrt_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  fp16_sqrt_result_stage_if.slave  bus
);

  localparam int RES_W = $bits(sqrt_res_t);

  sqrt_res_t new_res;
  sqrt_res_t main_d;
  sqrt_res_t main_q;
  sqrt_res_t skid_q;
  occ_e      state_q;
  occ_e      state_d;
  logic      in_ready_q;
  logic      accept;
  logic      drain;
  logic      main_en;
  logic      skid_en;

  fp16_sqrt_round_pack #(.ROUND_EN(ROUND_EN)) u_round_pack (
    .in_sign     (bus.in_sign),
    .in_exp      (bus.in_exp),
    .in_root     (bus.in_root),
    .in_rem_nz   (bus.in_rem_nz),
    .in_is_nan   (bus.in_is_nan),
    .in_is_inf   (bus.in_is_inf),
    .in_is_zero  (bus.in_is_zero),
    .in_nan_mant (bus.in_nan_mant),
    .res         (new_res)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_en = 1'b1;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en = 1'b1;
          state_d = OCC_TWO;
        end else if (drain) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (drain) begin
          main_en = 1'b1;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // In TWO no accept can happen, so main only ever refills from skid there.
  mux2_n #(.N(RES_W)) u_main_mux (
    .a   (new_res),
    .b   (skid_q),
    .sel (state_q == OCC_TWO),
    .y   (main_d)
  );

  register_n #(.N(RES_W)) u_main_reg (
    .clk (clk), .rst (rst), .en (main_en), .d (main_d), .q (main_q)
  );

  register_n #(.N(RES_W)) u_skid_reg (
    .clk (clk), .rst (rst), .en (skid_en), .d (new_res), .q (skid_q)
  );

  register_n #(.N(1), .RST_VAL(1'b1)) u_ready_reg (
    .clk (clk), .rst (rst), .en (1'b1), .d (state_d != OCC_TWO), .q (in_ready_q)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != OCC_EMPTY);
  assign bus.out_data    = main_q.data;
  assign bus.out_inexact = main_q.inexact;

endmodule

// File: tb/tb_fp16_sqrt_result_stage.sv
// Scoreboard bench: a rounding and a truncating instance share stimulus; a monitor checks both.
module tb_fp16_sqrt_result_stage;
  import fp16_sqrt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp16_sqrt_result_stage_if bus_r();
  fp16_sqrt_result_stage_if bus_t();

  assign bus_t.in_valid    = bus_r.in_valid;
  assign bus_t.in_sign     = bus_r.in_sign;
  assign bus_t.in_exp      = bus_r.in_exp;
  assign bus_t.in_root     = bus_r.in_root;
  assign bus_t.in_rem_nz   = bus_r.in_rem_nz;
  assign bus_t.in_is_nan   = bus_r.in_is_nan;
  assign bus_t.in_is_inf   = bus_r.in_is_inf;
  assign bus_t.in_is_zero  = bus_r.in_is_zero;
  assign bus_t.in_nan_mant = bus_r.in_nan_mant;
  assign bus_t.out_ready   = bus_r.out_ready;

  fp16_sqrt_result_stage #(.ROUND_EN(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  fp16_sqrt_result_stage #(.ROUND_EN(1'b0)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  logic [16:0] q_r[$];
  logic [16:0] q_t[$];
  logic [16:0] exp_r_cur, exp_t_cur;
  bit held_r, held_t;
  logic [16:0] hv_r, hv_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: value-level rounding on the integer significand.
  function automatic logic [16:0] model(input bit re, input bit sign, input int e,
                                        input logic [11:0] root, input bit rem,
                                        input bit nan, input bit inf, input bit zero,
                                        input logic [9:0] pl);
    int sig, eb;
    bit g;
    logic [15:0] d;
    if (nan)  return {sign, 5'h1F, pl, 1'b0};
    if (inf)  return {16'h7C00, 1'b0};
    if (zero) return {sign, 15'b0, 1'b0};
    sig = int'(root[11:1]);
    g = root[0];
    if (re && g && (rem || (sig % 2 == 1))) sig = sig + 1;
    if (sig == 2048) begin sig = 1024; e = e + 1; end
    eb = e + 15;
    if (eb >= 31)     d = 16'h7C00;
    else if (eb <= 0) d = {sign, 15'b0};
    else              d = {1'b0, 5'(eb), 10'(sig - 1024)};
    return {d, g | rem};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held_r = 1'b0;
      held_t = 1'b0;
    end else begin
      if (held_r) chk("hold_r", {bus_r.out_valid, bus_r.out_data, bus_r.out_inexact}, {1'b1, hv_r});
      if (held_t) chk("hold_t", {bus_t.out_valid, bus_t.out_data, bus_t.out_inexact}, {1'b1, hv_t});
      held_r = bus_r.out_valid && !bus_r.out_ready;
      held_t = bus_t.out_valid && !bus_t.out_ready;
      hv_r = {bus_r.out_data, bus_r.out_inexact};
      hv_t = {bus_t.out_data, bus_t.out_inexact};
      if (bus_r.out_valid && bus_r.out_ready) begin
        if (q_r.size() == 0) chk("extra_word_r", 1, 0);
        else chk("word_r", {bus_r.out_data, bus_r.out_inexact}, q_r.pop_front());
      end
      if (bus_t.out_valid && bus_t.out_ready) begin
        if (q_t.size() == 0) chk("extra_word_t", 1, 0);
        else chk("word_t", {bus_t.out_data, bus_t.out_inexact}, q_t.pop_front());
      end
      if (bus_r.in_valid && bus_r.in_ready) begin
        q_r.push_back(exp_r_cur);
        q_t.push_back(exp_t_cur);
        n_acc++;
      end
    end
  end

  task automatic set_word(input bit sign, input int e, input logic [11:0] root, input bit rem,
                          input bit nan, input bit inf, input bit zero, input logic [9:0] pl,
                          input logic [16:0] er, input logic [16:0] et);
    bus_r.in_sign = sign;
    bus_r.in_exp = 7'(e);
    bus_r.in_root = root;
    bus_r.in_rem_nz = rem;
    bus_r.in_is_nan = nan;
    bus_r.in_is_inf = inf;
    bus_r.in_is_zero = zero;
    bus_r.in_nan_mant = pl;
    exp_r_cur = er;
    exp_t_cur = et;
  endtask

  task automatic random_word();
    bit sign, rem, nan, inf, zero;
    int e, cls;
    logic [11:0] root;
    logic [9:0] pl;
    sign = 1'($urandom);
    rem = 1'($urandom);
    e = int'($urandom_range(0, 29)) - 14;
    root = {1'b1, 11'($urandom)};
    pl = {1'b1, 9'($urandom)};
    cls = int'($urandom_range(0, 9));
    nan = (cls == 0);
    inf = (cls == 1);
    zero = (cls == 2);
    set_word(sign, e, root, rem, nan, inf, zero, pl,
             model(1'b1, sign, e, root, rem, nan, inf, zero, pl),
             model(1'b0, sign, e, root, rem, nan, inf, zero, pl));
  endtask

  task automatic send();
    bit done = 1'b0;
    bus_r.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_r.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
    end
    bus_r.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q_r.size() == 0 && q_t.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_r", q_r.size(), 0);
    chk("drain_t", q_t.size(), 0);
  endtask

  typedef struct packed {
    logic        sign;
    logic [6:0]  e;
    logic [11:0] root;
    logic        rem, nan, inf, zero;
    logic [9:0]  pl;
    logic [16:0] er, et;
  } vec_t;

  vec_t dir [7];
  bit rand_done;
  int acc0;

  initial begin
    dir[0] = '{1'b0, 7'd1, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0,   {16'h4000, 1'b0}, {16'h4000, 1'b0}};
    dir[1] = '{1'b0, 7'd0, 12'h801, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0,   {16'h3C00, 1'b1}, {16'h3C00, 1'b1}};
    dir[2] = '{1'b0, 7'd0, 12'h803, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0,   {16'h3C02, 1'b1}, {16'h3C01, 1'b1}};
    dir[3] = '{1'b0, 7'd0, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0,   {16'h4000, 1'b1}, {16'h3FFF, 1'b1}};
    dir[4] = '{1'b1, 7'd0, 12'h8FF, 1'b1, 1'b1, 1'b0, 1'b0, 10'h200, {16'hFE00, 1'b0}, {16'hFE00, 1'b0}};
    dir[5] = '{1'b1, 7'd0, 12'h801, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0,   {16'h7C00, 1'b0}, {16'h7C00, 1'b0}};
    dir[6] = '{1'b1, 7'd0, 12'h801, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0,   {16'h8000, 1'b0}, {16'h8000, 1'b0}};

    bus_r.in_valid = 1'b0;
    bus_r.out_ready = 1'b0;
    set_word(0, 0, 12'h800, 0, 0, 0, 0, 10'h0, 17'h0, 17'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus_r.out_valid, 0);
    chk("rst_in_ready", bus_r.in_ready, 1);
    chk("rst_out_data", bus_r.out_data, 16'h0000);
    chk("rst_out_inexact", bus_r.out_inexact, 0);
    chk("rst_t", {bus_t.out_valid, bus_t.in_ready, bus_t.out_data, bus_t.out_inexact}, {1'b0, 1'b1, 16'h0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors; the first one also checks single-edge latency.
    bus_r.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_word(dir[i].sign, int'($signed(dir[i].e)), dir[i].root, dir[i].rem, dir[i].nan,
               dir[i].inf, dir[i].zero, dir[i].pl, dir[i].er, dir[i].et);
      send();
      if (i == 0) chk("latency", {bus_r.out_valid, bus_r.out_data}, {1'b1, 16'h4000});
    end
    drain();

    // Backpressure: two words fill both slots, a third is refused.
    bus_r.out_ready = 1'b0;
    acc0 = n_acc;
    random_word();
    send();
    random_word();
    send();
    chk("bp_in_ready_r", bus_r.in_ready, 0);
    chk("bp_in_ready_t", bus_t.in_ready, 0);
    chk("bp_accepted", n_acc - acc0, 2);
    random_word();
    bus_r.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_still_full", {bus_r.in_ready, bus_r.out_valid}, {1'b0, 1'b1});
    chk("bp_accepted_3", n_acc - acc0, 2);
    bus_r.out_ready = 1'b1;
    send();
    random_word();
    send();
    drain();
    chk("bp_total", n_acc - acc0, 4);

    // Reset with both slots occupied discards them immediately.
    bus_r.out_ready = 1'b0;
    random_word();
    send();
    random_word();
    send();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {bus_r.out_valid, bus_t.out_valid}, 0);
    chk("mid_rst_in_ready", {bus_r.in_ready, bus_t.in_ready}, 2'b11);
    q_r.delete();
    q_t.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_r.out_ready = 1'b1;
    random_word();
    send();
    chk("post_rst_first", {bus_r.out_valid, bus_r.out_data, bus_r.out_inexact}, {1'b1, exp_r_cur});
    drain();

    // Random stream with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          random_word();
          send();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus_r.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    bus_r.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
